// File: rtl/rotation_pkg.sv
// Shared register offsets, rotation encodings and the effective-rotation helper
// for the rotation APB register slice.
package rotation_pkg;

  localparam logic [31:0] P_SOURCE        = 32'h00;
  localparam logic [31:0] P_DEST          = 32'h04;
  localparam logic [31:0] P_HEIGHT        = 32'h08;
  localparam logic [31:0] P_WIDTH         = 32'h0C;
  localparam logic [31:0] P_NEW_HEIGHT    = 32'h10;
  localparam logic [31:0] P_NEW_WIDTH     = 32'h14;
  localparam logic [31:0] P_MODE          = 32'h18;
  localparam logic [31:0] P_DIRECTION     = 32'h1C;
  localparam logic [31:0] P_START         = 32'h20;
  localparam logic [31:0] P_SOFT_RESET    = 32'h24;
  localparam logic [31:0] P_INTR_MASK     = 32'h28;
  localparam logic [31:0] P_RAW_STATUS    = 32'h2C;
  localparam logic [31:0] P_MASKED_STATUS = 32'h30;
  localparam logic [31:0] P_INTR_CLEAR    = 32'h34;

  localparam logic [1:0] P_DEG_0   = 2'd0;
  localparam logic [1:0] P_DEG_90  = 2'd1;
  localparam logic [1:0] P_DEG_180 = 2'd2;
  localparam logic [1:0] P_DEG_270 = 2'd3;

  localparam logic P_CCW = 1'b0;
  localparam logic P_CW  = 1'b1;

  // A counter-clockwise request of N quarter turns is the clockwise turn (4 - N) mod 4.
  function automatic logic [1:0] rot_effective(input logic [1:0] mode, input logic dir);
    logic [2:0] w_ccw;
    w_ccw = 3'd4 - {1'b0, mode};
    if (dir == P_CW) return mode;
    return w_ccw[1:0];
  endfunction

endpackage

// File: rtl/rotation_dim_calc.sv
// Registered output-image dimensions: odd quarter turns swap height and width.
module rotation_dim_calc
  import rotation_pkg::*;
#(
  parameter int P_DIM_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [P_DIM_W-1:0] i_height,
  input  logic [P_DIM_W-1:0] i_width,
  input  logic [1:0]         i_rot,
  output logic [P_DIM_W-1:0] o_new_height,
  output logic [P_DIM_W-1:0] o_new_width
);

  logic w_swap;

  assign w_swap = (i_rot == P_DEG_90) || (i_rot == P_DEG_270);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_new_height <= '0;
      o_new_width  <= '0;
    end else begin
      o_new_height <= w_swap ? i_width  : i_height;
      o_new_width  <= w_swap ? i_height : i_width;
    end
  end

endmodule

// File: rtl/rotation_apb_regs.sv
// APB register file feeding the rotation core: configuration, start/soft-reset
// pulses and the done interrupt. Optional PSLVERR port under ROT_REG_PSLVERR_EN.
module rotation_apb_regs
  import rotation_pkg::*;
#(
  parameter int P_DIM_W  = 16,
  parameter int P_ADDR_W = 8
) (
  input  logic               I_PCLK,
  input  logic               I_PRESET_N,
  input  logic               I_REG_PSEL,
  input  logic               I_REG_PENABLE,
  input  logic               I_REG_PWRITE,
  input  logic [31:0]        I_REG_PADDR,
  input  logic [31:0]        I_REG_PWDATA,
  output logic [31:0]        O_REG_PRDATA,
  input  logic               I_CORE_BUSY,
  input  logic               I_CORE_DONE,
  output logic [31:0]        O_CFG_SRC,
  output logic [31:0]        O_CFG_DST,
  output logic [P_DIM_W-1:0] O_CFG_HEIGHT,
  output logic [P_DIM_W-1:0] O_CFG_WIDTH,
  output logic [P_DIM_W-1:0] O_CFG_NEW_HEIGHT,
  output logic [P_DIM_W-1:0] O_CFG_NEW_WIDTH,
  output logic [1:0]         O_CFG_ROT,
  output logic               O_START_PULSE,
  output logic               O_SOFT_RST_PULSE,
  output logic               O_INTR_DONE
`ifdef ROT_REG_PSLVERR_EN
  ,output logic              O_REG_PSLVERR
`endif
);

  logic [31:0]        r_src;
  logic [31:0]        r_dst;
  logic [P_DIM_W-1:0] r_height;
  logic [P_DIM_W-1:0] r_width;
  logic [1:0]         r_mode;
  logic               r_dir;
  logic               r_mask;
  logic               r_pending;
  logic               r_start_pulse;
  logic               r_soft_rst_pulse;
  logic               r_intr_done;
  logic [31:0]        r_prdata;

  logic [31:0]        w_offset;
  logic               w_wr_en;
  logic               w_rd_setup;
  logic               w_busy;
  logic               w_dims_ok;
  logic               w_start_req;
  logic               w_start_ok;
  logic               w_soft_req;
  logic               w_clr_req;
  logic [1:0]         w_rot;
  logic [P_DIM_W-1:0] w_new_height;
  logic [P_DIM_W-1:0] w_new_width;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_offset   = 32'(I_REG_PADDR[P_ADDR_W-1:0]);
  assign w_unused   = ^I_REG_PADDR[31:P_ADDR_W];
  assign w_wr_en    = I_REG_PSEL & I_REG_PENABLE & I_REG_PWRITE;
  assign w_rd_setup = I_REG_PSEL & ~I_REG_PENABLE & ~I_REG_PWRITE;

  // A start pulse already in flight counts as busy so a second launch cannot sneak in.
  assign w_busy      = I_CORE_BUSY | r_start_pulse;
  assign w_dims_ok   = (r_height != '0) && (r_width != '0);
  assign w_start_req = w_wr_en && (w_offset == P_START) && I_REG_PWDATA[0];
  assign w_start_ok  = w_start_req && !w_busy && w_dims_ok;
  assign w_soft_req  = w_wr_en && (w_offset == P_SOFT_RESET) && I_REG_PWDATA[0];
  assign w_clr_req   = w_wr_en && (w_offset == P_INTR_CLEAR) && I_REG_PWDATA[0];

  assign w_rot = rot_effective(r_mode, r_dir);

  rotation_dim_calc #(
    .P_DIM_W (P_DIM_W)
  ) u_dim_calc (
    .i_clk        (I_PCLK),
    .i_rst_n      (I_PRESET_N),
    .i_height     (r_height),
    .i_width      (r_width),
    .i_rot        (w_rot),
    .o_new_height (w_new_height),
    .o_new_width  (w_new_width)
  );

  always_comb begin
    w_rdata = '0;
    case (w_offset)
      P_SOURCE:        w_rdata = r_src;
      P_DEST:          w_rdata = r_dst;
      P_HEIGHT:        w_rdata = 32'(r_height);
      P_WIDTH:         w_rdata = 32'(r_width);
      P_NEW_HEIGHT:    w_rdata = 32'(w_new_height);
      P_NEW_WIDTH:     w_rdata = 32'(w_new_width);
      P_MODE:          w_rdata = {30'd0, r_mode};
      P_DIRECTION:     w_rdata = {31'd0, r_dir};
      P_START:         w_rdata = {31'd0, w_busy};
      P_INTR_MASK:     w_rdata = {31'd0, r_mask};
      P_RAW_STATUS:    w_rdata = {31'd0, r_pending};
      P_MASKED_STATUS: w_rdata = {31'd0, r_pending & ~r_mask};
      default:         w_rdata = '0;
    endcase
  end

  // Soft reset beats a coincident done, while a done beats a coincident clear.
  always_ff @(posedge I_PCLK) begin
    if (!I_PRESET_N) begin
      r_src            <= '0;
      r_dst            <= '0;
      r_height         <= '0;
      r_width          <= '0;
      r_mode           <= P_DEG_0;
      r_dir            <= P_CCW;
      r_mask           <= 1'b1;
      r_pending        <= 1'b0;
      r_start_pulse    <= 1'b0;
      r_soft_rst_pulse <= 1'b0;
      r_intr_done      <= 1'b0;
      r_prdata         <= '0;
    end else begin
      r_start_pulse    <= w_start_ok;
      r_soft_rst_pulse <= w_soft_req;
      r_intr_done      <= r_pending & ~r_mask;

      if (w_wr_en && !w_busy) begin
        case (w_offset)
          P_SOURCE:    r_src    <= I_REG_PWDATA;
          P_DEST:      r_dst    <= I_REG_PWDATA;
          P_HEIGHT:    r_height <= I_REG_PWDATA[P_DIM_W-1:0];
          P_WIDTH:     r_width  <= I_REG_PWDATA[P_DIM_W-1:0];
          P_MODE:      r_mode   <= I_REG_PWDATA[1:0];
          P_DIRECTION: r_dir    <= I_REG_PWDATA[0];
          default:     ;
        endcase
      end

      if (w_wr_en && (w_offset == P_INTR_MASK)) r_mask <= I_REG_PWDATA[0];

      if (w_soft_req)       r_pending <= 1'b0;
      else if (I_CORE_DONE) r_pending <= 1'b1;
      else if (w_clr_req)   r_pending <= 1'b0;

      if (w_rd_setup) r_prdata <= w_rdata;
    end
  end

`ifdef ROT_REG_PSLVERR_EN
  logic w_mapped;
  logic w_locked_reg;
  logic w_ro_reg;
  logic w_err;

  always_comb begin
    w_mapped     = 1'b0;
    w_locked_reg = 1'b0;
    w_ro_reg     = 1'b0;
    case (w_offset)
      P_SOURCE, P_DEST, P_HEIGHT, P_WIDTH, P_MODE, P_DIRECTION: begin
        w_mapped     = 1'b1;
        w_locked_reg = 1'b1;
      end
      P_NEW_HEIGHT, P_NEW_WIDTH: begin
        w_mapped     = 1'b1;
        w_locked_reg = 1'b1;
        w_ro_reg     = 1'b1;
      end
      P_RAW_STATUS, P_MASKED_STATUS: begin
        w_mapped = 1'b1;
        w_ro_reg = 1'b1;
      end
      P_START, P_SOFT_RESET, P_INTR_MASK, P_INTR_CLEAR: w_mapped = 1'b1;
      default: ;
    endcase
  end

  assign w_err = !w_mapped
               || (I_REG_PWRITE && w_locked_reg && w_busy)
               || (w_start_req && !w_start_ok)
               || (I_REG_PWRITE && w_ro_reg);

  assign O_REG_PSLVERR = I_PRESET_N & I_REG_PSEL & I_REG_PENABLE & w_err;
`endif

  assign O_REG_PRDATA     = r_prdata;
  assign O_CFG_SRC        = r_src;
  assign O_CFG_DST        = r_dst;
  assign O_CFG_HEIGHT     = r_height;
  assign O_CFG_WIDTH      = r_width;
  assign O_CFG_NEW_HEIGHT = w_new_height;
  assign O_CFG_NEW_WIDTH  = w_new_width;
  assign O_CFG_ROT        = w_rot;
  assign O_START_PULSE    = r_start_pulse;
  assign O_SOFT_RST_PULSE = r_soft_rst_pulse;
  assign O_INTR_DONE      = r_intr_done;

endmodule

// File: tb/tb_rotation_apb_regs.sv
// Scoreboard bench for rotation_apb_regs: stimulus queues expected values and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_rotation_apb_regs;

  logic        I_PCLK;
  logic        I_PRESET_N;
  logic        I_REG_PSEL;
  logic        I_REG_PENABLE;
  logic        I_REG_PWRITE;
  logic [31:0] I_REG_PADDR;
  logic [31:0] I_REG_PWDATA;
  logic [31:0] O_REG_PRDATA;
  logic        I_CORE_BUSY;
  logic        I_CORE_DONE;
  logic [31:0] O_CFG_SRC;
  logic [31:0] O_CFG_DST;
  logic [15:0] O_CFG_HEIGHT;
  logic [15:0] O_CFG_WIDTH;
  logic [15:0] O_CFG_NEW_HEIGHT;
  logic [15:0] O_CFG_NEW_WIDTH;
  logic [1:0]  O_CFG_ROT;
  logic        O_START_PULSE;
  logic        O_SOFT_RST_PULSE;
  logic        O_INTR_DONE;
`ifdef ROT_REG_PSLVERR_EN
  logic        O_REG_PSLVERR;
`endif

  rotation_apb_regs #(
    .P_DIM_W  (16),
    .P_ADDR_W (8)
  ) dut (
    .I_PCLK           (I_PCLK),
    .I_PRESET_N       (I_PRESET_N),
    .I_REG_PSEL       (I_REG_PSEL),
    .I_REG_PENABLE    (I_REG_PENABLE),
    .I_REG_PWRITE     (I_REG_PWRITE),
    .I_REG_PADDR      (I_REG_PADDR),
    .I_REG_PWDATA     (I_REG_PWDATA),
    .O_REG_PRDATA     (O_REG_PRDATA),
    .I_CORE_BUSY      (I_CORE_BUSY),
    .I_CORE_DONE      (I_CORE_DONE),
    .O_CFG_SRC        (O_CFG_SRC),
    .O_CFG_DST        (O_CFG_DST),
    .O_CFG_HEIGHT     (O_CFG_HEIGHT),
    .O_CFG_WIDTH      (O_CFG_WIDTH),
    .O_CFG_NEW_HEIGHT (O_CFG_NEW_HEIGHT),
    .O_CFG_NEW_WIDTH  (O_CFG_NEW_WIDTH),
    .O_CFG_ROT        (O_CFG_ROT),
    .O_START_PULSE    (O_START_PULSE),
    .O_SOFT_RST_PULSE (O_SOFT_RST_PULSE),
    .O_INTR_DONE      (O_INTR_DONE)
`ifdef ROT_REG_PSLVERR_EN
    ,.O_REG_PSLVERR   (O_REG_PSLVERR)
`endif
  );

  localparam int SEL_PRDATA = 0;
  localparam int SEL_ROT    = 1;
  localparam int SEL_NEWH   = 2;
  localparam int SEL_NEWW   = 3;
  localparam int SEL_STARTS = 4;
  localparam int SEL_SOFTS  = 5;
  localparam int SEL_INTR   = 6;
  localparam int SEL_SRC    = 7;
  localparam int SEL_ERR    = 8;
  localparam int SEL_HEIGHT = 9;
  localparam int SEL_DST    = 10;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t scoreQ[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    startCount = 0;
  int    softCount  = 0;
  logic  lastErr    = 1'b0;
  int    snap;

  initial I_PCLK = 1'b0;
  always #5 I_PCLK = ~I_PCLK;

  // Count the cycles each pulse is high, sampled just after the edge that set it.
  always begin
    @(posedge I_PCLK);
    #2;
    if (O_START_PULSE === 1'b1) startCount++;
    if (O_SOFT_RST_PULSE === 1'b1) softCount++;
  end

  function automatic logic [31:0] actualOf(input int sel);
    case (sel)
      SEL_PRDATA: return O_REG_PRDATA;
      SEL_ROT:    return 32'(O_CFG_ROT);
      SEL_NEWH:   return 32'(O_CFG_NEW_HEIGHT);
      SEL_NEWW:   return 32'(O_CFG_NEW_WIDTH);
      SEL_STARTS: return 32'(startCount);
      SEL_SOFTS:  return 32'(softCount);
      SEL_INTR:   return 32'(O_INTR_DONE);
      SEL_SRC:    return O_CFG_SRC;
      SEL_ERR:    return 32'(lastErr);
      SEL_HEIGHT: return 32'(O_CFG_HEIGHT);
      SEL_DST:    return O_CFG_DST;
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: every falling edge, drain whatever expectations the stimulus has posted.
  initial begin
    item_t it;
    logic [31:0] act;
    forever begin
      @(negedge I_PCLK);
      while (scoreQ.size() > 0) begin
        it  = scoreQ.pop_front();
        act = actualOf(it.sel);
        compared++;
        if (act !== it.exp) begin
          mismatched++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  // One complete APB transfer; optionally pulses done or drops reset on the commit edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input bit doneAtCommit = 1'b0,
                               input bit abortReset = 1'b0);
    @(posedge I_PCLK); #1;
    I_REG_PSEL    = 1'b1;
    I_REG_PENABLE = 1'b0;
    I_REG_PWRITE  = wr;
    I_REG_PADDR   = addr;
    I_REG_PWDATA  = data;
    @(posedge I_PCLK); #1;
    I_REG_PENABLE = 1'b1;
    if (doneAtCommit) I_CORE_DONE = 1'b1;
    if (abortReset) I_PRESET_N = 1'b0;
    #1;
`ifdef ROT_REG_PSLVERR_EN
    lastErr = O_REG_PSLVERR;
`endif
    @(posedge I_PCLK); #1;
    I_REG_PSEL    = 1'b0;
    I_REG_PENABLE = 1'b0;
    I_REG_PWRITE  = 1'b0;
    I_CORE_DONE   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    scoreQ.push_back(it);
    @(negedge I_PCLK); #1;
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, addr, 32'h0);
    checkOutput(name, SEL_PRDATA, exp);
  endtask

  task automatic errCheck(input string name, input logic exp);
`ifdef ROT_REG_PSLVERR_EN
    checkOutput(name, SEL_ERR, 32'(exp));
`else
    if (exp === 1'bx) $display("[TB] %s", name);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge I_PCLK);
    #1;
  endtask

  task automatic pulseDone();
    @(posedge I_PCLK); #1;
    I_CORE_DONE = 1'b1;
    @(posedge I_PCLK); #1;
    I_CORE_DONE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    I_PRESET_N    = 1'b0;
    I_REG_PSEL    = 1'b0;
    I_REG_PENABLE = 1'b0;
    I_REG_PWRITE  = 1'b0;
    I_REG_PADDR   = '0;
    I_REG_PWDATA  = '0;
    I_CORE_BUSY   = 1'b0;
    I_CORE_DONE   = 1'b0;
    repeat (3) @(posedge I_PCLK);
    #1 I_PRESET_N = 1'b1;

    // Reset state: outputs idle, only INTR_MASK reads back as 1.
    checkOutput("rst_rot",    SEL_ROT,    32'd0);
    compared++;
    if (O_START_PULSE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_start_pulse: got %b, expected 0", O_START_PULSE);
    end
    checkOutput("rst_newh",   SEL_NEWH,   32'd0);
    checkOutput("rst_intr",   SEL_INTR,   32'd0);
    checkOutput("rst_src",    SEL_SRC,    32'd0);
    checkOutput("rst_prdata", SEL_PRDATA, 32'd0);
    for (int off = 0; off <= 'h34; off += 4)
      readCheck($sformatf("rst_read_%02h", off), 32'(off), (off == 'h28) ? 32'd1 : 32'd0);
    checkOutput("rst_starts", SEL_STARTS, 32'd0);

    // Effective rotation and rotated dimensions.
    applyStimulus(1'b1, 32'h08, 32'd4);
    applyStimulus(1'b1, 32'h0C, 32'd6);
    applyStimulus(1'b1, 32'h18, 32'd1);
    applyStimulus(1'b1, 32'h1C, 32'd1);
    idle(1);
    checkOutput("cw90_rot",  SEL_ROT,  32'd1);
    checkOutput("cw90_newh", SEL_NEWH, 32'd6);
    checkOutput("cw90_neww", SEL_NEWW, 32'd4);
    compared++;
    if (O_CFG_ROT !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL cw90_rot_direct: got %0d, expected 1", O_CFG_ROT);
    end
    applyStimulus(1'b1, 32'h1C, 32'd0);
    idle(1);
    checkOutput("ccw90_rot",  SEL_ROT,  32'd3);
    checkOutput("ccw90_newh", SEL_NEWH, 32'd6);
    checkOutput("ccw90_neww", SEL_NEWW, 32'd4);
    applyStimulus(1'b1, 32'h18, 32'd2);
    idle(1);
    checkOutput("ccw180_rot",  SEL_ROT,  32'd2);
    checkOutput("ccw180_newh", SEL_NEWH, 32'd4);
    checkOutput("ccw180_neww", SEL_NEWW, 32'd6);
    readCheck("rd_new_height", 32'h10, 32'd4);
    readCheck("rd_new_width",  32'h14, 32'd6);
    applyStimulus(1'b1, 32'h10, 32'd9);
    errCheck("ro_write_err", 1'b1);
    readCheck("ro_write_ignored", 32'h10, 32'd4);
    readCheck("unmapped_read", 32'h40, 32'd0);
    errCheck("unmapped_err", 1'b1);

    // Start pulse, START=0 no-op, busy lock.
    applyStimulus(1'b1, 32'h08, 32'd1);
    errCheck("ok_write_err", 1'b0);
    applyStimulus(1'b1, 32'h0C, 32'd1);
    idle(1);
    snap = startCount;
    applyStimulus(1'b1, 32'h20, 32'd1);
    errCheck("start_ok_err", 1'b0);
    idle(3);
    checkOutput("start_one_pulse", SEL_STARTS, 32'(snap + 1));
    compared++;
    if (startCount !== snap + 1) begin
      mismatched++;
      $display("[TB] FAIL start_count_direct: got %0d, expected %0d", startCount, snap + 1);
    end
    applyStimulus(1'b1, 32'h20, 32'd0);
    idle(2);
    checkOutput("start_zero_noop", SEL_STARTS, 32'(snap + 1));
    I_CORE_BUSY = 1'b1;
    readCheck("busy_read_start", 32'h20, 32'd1);
    applyStimulus(1'b1, 32'h0C, 32'd9);
    errCheck("locked_write_err", 1'b1);
    readCheck("locked_width", 32'h0C, 32'd1);
    applyStimulus(1'b1, 32'h20, 32'd1);
    errCheck("busy_start_err", 1'b1);
    idle(2);
    checkOutput("busy_start_nopulse", SEL_STARTS, 32'(snap + 1));
    I_CORE_BUSY = 1'b0;
    applyStimulus(1'b1, 32'h0C, 32'd0);
    applyStimulus(1'b1, 32'h20, 32'd1);
    errCheck("zero_dim_err", 1'b1);
    idle(2);
    checkOutput("zero_dim_nopulse", SEL_STARTS, 32'(snap + 1));
    readCheck("idle_read_start", 32'h20, 32'd0);

    // Interrupt set / clear priority.
    applyStimulus(1'b1, 32'h28, 32'd0);
    pulseDone();
    readCheck("raw_after_done", 32'h2C, 32'd1);
    checkOutput("intr_after_done", SEL_INTR, 32'd1);
    readCheck("masked_after_done", 32'h30, 32'd1);
    applyStimulus(1'b1, 32'h34, 32'd1, 1'b1);
    readCheck("set_beats_clear", 32'h2C, 32'd1);
    applyStimulus(1'b1, 32'h34, 32'd1);
    idle(2);
    checkOutput("intr_cleared", SEL_INTR, 32'd0);
    readCheck("raw_cleared", 32'h2C, 32'd0);

    // Soft reset clears pending but keeps configuration.
    applyStimulus(1'b1, 32'h00, 32'h1122_3344);
    applyStimulus(1'b1, 32'h04, 32'h5566_7788);
    pulseDone();
    idle(2);
    snap = softCount;
    applyStimulus(1'b1, 32'h24, 32'd1);
    idle(2);
    checkOutput("soft_one_pulse", SEL_SOFTS, 32'(snap + 1));
    compared++;
    if (softCount !== snap + 1) begin
      mismatched++;
      $display("[TB] FAIL soft_count_direct: got %0d, expected %0d", softCount, snap + 1);
    end
    readCheck("soft_raw", 32'h2C, 32'd0);
    checkOutput("soft_intr", SEL_INTR, 32'd0);
    readCheck("soft_src", 32'h00, 32'h1122_3344);
    readCheck("soft_dst", 32'h04, 32'h5566_7788);
    readCheck("soft_height", 32'h08, 32'd1);
    readCheck("soft_read0", 32'h24, 32'd0);
    checkOutput("soft_cfg_dst", SEL_DST, 32'h5566_7788);

    // Soft reset and done on the same edge: the clear wins.
    pulseDone();
    applyStimulus(1'b1, 32'h24, 32'd1, 1'b1);
    readCheck("soft_beats_done", 32'h2C, 32'd0);

    // Reset dropped during the access phase aborts the write.
    applyStimulus(1'b1, 32'h00, 32'hDEAD_BEEF, 1'b0, 1'b1);
    I_PRESET_N = 1'b1;
    readCheck("abort_src", 32'h00, 32'd0);
    checkOutput("abort_cfg_src", SEL_SRC, 32'd0);
    compared++;
    if (O_CFG_SRC !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL abort_src_direct: got 0x%08h, expected 0", O_CFG_SRC);
    end
    checkOutput("abort_height", SEL_HEIGHT, 32'd0);
    readCheck("abort_mask", 32'h28, 32'd1);

    idle(2);
    if (mismatched != 0)
      $display("[TB] FAIL %0d mismatches", mismatched);
    else
      $display("[TB] PASS all checks");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
